program_boot_sequencer: RTL
===========================

// Module: program_boot_sequencer
// PURPOSE
//  Sequences the RISC-V core's boot. Streams NUM_INSTRUCTIONS words from the instruction-init BRAM
//  into the processor instruction memory, compensating for the BRAM read latency.
//  Holds the core in reset until the load completes, then paces execution with a one-cycle
//  clock-enable tick (free-run divider or single-step), and halts on processor done.
//  Replaces the ad-hoc load counter and the divided processor clock in top_level.
// PARAMETERS
//  NUM_INSTRUCTIONS  28     words to load; 1..2**ADDR_WIDTH
//  ADDR_WIDTH        6      BRAM / imem address width
//  DATA_WIDTH        32     instruction width
//  BRAM_LATENCY      2      BRAM read latency in cycles (HIGH_PERFORMANCE = 2); >=1
//  STEP_DIV          65536  free-run tick period in pixel clocks; >=2
// PORTS
//  pixel_clk_in   in   1           sole clock (clk_pixel)
//  rst_in         in   1           synchronous, active-low reset
//  start_in       in   1           1-cycle pulse: begin or restart load
//  step_mode_in   in   1           0 = free-run ticks, 1 = single-step
//  step_in        in   1           1-cycle pulse: one tick in single-step mode
//  proc_done_in   in   1           core reports program finished
//  bram_addr_out  out  ADDR_WIDTH  init-BRAM read address
//  bram_data_in   in   DATA_WIDTH  init-BRAM read data, BRAM_LATENCY cycles after address
//  imem_we_out    out  1           instruction-memory write enable
//  imem_addr_out  out  ADDR_WIDTH  instruction-memory write address
//  imem_data_out  out  DATA_WIDTH  instruction-memory write data
//  proc_rst_out   out  1           active-high core reset
//  proc_tick_out  out  1           1-cycle clock enable for the core
//  loaded_out     out  1           high in RUN and HALT
//  state_out      out  3           IDLE=0 LOAD=1 DRAIN=2 RUN=3 HALT=4 (debug / seven-seg)
// BEHAVIOUR
//  Reset (rst_in=0 at an edge)
//  - Next cycle: state IDLE; proc_rst_out=1; all other outputs 0; pipeline valids cleared.
//  - Applies mid-operation too: an in-flight write stops immediately; imem contents are untouched.
//  FSM
//  - IDLE: start_in -> LOAD, with load counter=0.
//  - LOAD: bram_addr_out=counter, increments every cycle. On the cycle it drives N-1 -> DRAIN.
//  - DRAIN: when the last pipelined write has been issued -> RUN.
//  - RUN: proc_rst_out=0, loaded_out=1. proc_done_in -> HALT.
//  - HALT: proc_rst_out stays 0; no ticks; loaded_out=1. start_in -> LOAD.
//  - start_in in RUN: -> LOAD. proc_rst_out=1 from the next cycle (reload abort).
//  - start_in in LOAD or DRAIN: ignored.
//  Load pipeline
//  - Address and a valid bit are delayed BRAM_LATENCY stages.
//  - imem_we_out=1 with imem_addr_out=k and imem_data_out=bram_data_in, exactly BRAM_LATENCY
//    cycles after bram_addr_out=k is driven.
//  - Timing for start_in at cycle 0:
//    - address k is driven at cycle 1+k;
//    - write k at cycle 1+k+BRAM_LATENCY;
//    - RUN is entered at cycle N+BRAM_LATENCY+1, with proc_rst_out falling that cycle.
//  - Exactly N writes per load, addresses 0..N-1 in order, with no gaps.
//  - proc_rst_out=1 throughout LOAD and DRAIN.
//  Tick generation (RUN only; registered, asserted the cycle after its cause)
//  - Free-run: the divider is cleared on RUN entry and wraps at STEP_DIV-1. A wrap produces one tick.
//    The first tick comes STEP_DIV cycles after RUN entry.
//  - Single-step: step_in produces exactly one tick. Back-to-back step_in gives back-to-back ticks.
//  - Changing step_mode_in clears the divider.
//  - proc_done_in in the same cycle as a tick cause: done wins, no tick.
//  - step_in outside RUN is ignored.
// TESTING
//  1. N=28, L=2, with init BRAM word k = 0xA000_0000+k. Pulse start_in at cycle 0
//     -> 28 writes on cycles 3..30 with data A000_0000..A000_001B;
//     proc_rst_out falls at cycle 31; state_out=3.
//  2. Free-run, STEP_DIV=4 -> ticks at RUN+4, +8, +12.
//     Raise proc_done_in at RUN+6 -> HALT; no tick at +8; proc_rst_out stays 0.
//  3. Single-step mode, pulse step_in 3 times (two of them adjacent) -> exactly 3 one-cycle ticks.
//     With step_mode_in=0 and STEP_DIV large -> no ticks.
//  4. Pull rst_in low at LOAD address 10 -> next cycle imem_we_out=0, state IDLE, proc_rst_out=1.
//     A new start_in reloads from address 0.
//  5. start_in during LOAD -> ignored (still exactly 28 writes).
//     start_in during RUN -> proc_rst_out=1 next cycle and a full reload from address 0.
//  6. Sweep BRAM_LATENCY=1 and 3 -> write k lags address k by the latency; RUN entry at N+L+1.

Source files
------------

// File: rtl/program_boot_sequencer.sv
// Boot sequencer: copies the init BRAM into instruction memory while holding the core in
// reset, then paces the core with single-cycle clock-enable ticks until it reports done.
module program_boot_sequencer #(
    parameter int NUM_INSTRUCTIONS = 28,
    parameter int ADDR_WIDTH       = 6,
    parameter int DATA_WIDTH       = 32,
    parameter int BRAM_LATENCY     = 2,
    parameter int STEP_DIV         = 65536
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  step_mode_in,
    input  logic                  step_in,
    input  logic                  proc_done_in,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic                  imem_we_out,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    output logic [DATA_WIDTH-1:0] imem_data_out,
    output logic                  proc_rst_out,
    output logic                  proc_tick_out,
    output logic                  loaded_out,
    output logic [2:0]            state_out
);

    localparam int DIV_WIDTH = $clog2(STEP_DIV);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INSTRUCTIONS - 1);
    localparam logic [DIV_WIDTH-1:0]  DIV_LAST  = DIV_WIDTH'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]                    cnt_q, cnt_d;
    logic [BRAM_LATENCY-1:0]                  pipe_valid_q, pipe_valid_d;
    logic [BRAM_LATENCY-1:0][ADDR_WIDTH-1:0]  pipe_addr_q, pipe_addr_d;
    logic [DIV_WIDTH-1:0]                     div_q, div_d;
    logic                                     tick_q, tick_d;
    logic                                     last_write;

    // The write for address k leaves the last stage in the same cycle its BRAM data arrives.
    assign last_write = pipe_valid_q[BRAM_LATENCY-1] &&
                        (pipe_addr_q[BRAM_LATENCY-1] == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (last_write) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start_in) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (proc_done_in) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (start_in) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pipe_valid_d    = '0;
        pipe_addr_d     = '0;
        pipe_valid_d[0] = (state_q == S_LOAD);
        pipe_addr_d[0]  = cnt_q;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_addr_d[i]  = pipe_addr_q[i-1];
        end
    end

    // Divider idles at zero outside free-run RUN, so RUN entry and mode changes restart it.
    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if ((state_q == S_RUN) && !step_mode_in) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_WIDTH'(1);
        end
        if ((state_q == S_RUN) && !proc_done_in && !start_in) begin
            tick_d = step_mode_in ? step_in : (div_q == DIV_LAST);
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pipe_valid_q <= '0;
            pipe_addr_q  <= '0;
            div_q        <= '0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_addr_q  <= pipe_addr_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
        end
    end

    assign bram_addr_out = (state_q == S_LOAD) ? cnt_q : '0;
    assign imem_we_out   = pipe_valid_q[BRAM_LATENCY-1];
    assign imem_addr_out = imem_we_out ? pipe_addr_q[BRAM_LATENCY-1] : '0;
    assign imem_data_out = imem_we_out ? bram_data_in : '0;
    assign proc_rst_out  = !((state_q == S_RUN) || (state_q == S_HALT));
    assign loaded_out    = (state_q == S_RUN) || (state_q == S_HALT);
    assign proc_tick_out = tick_q;
    assign state_out     = state_q;

endmodule
